cla_16bit: RTL and testbench

//   16-bit signed two's-complement adder/subtractor built as a carry-lookahead adder (CLA).

---
 rtl/cla_16bit.sv | 74 +++++++
 tb/tb_cla_16bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cla_16bit.sv
// 16-bit signed adder/subtractor: four 4-bit carry-lookahead slices under a second-level
// lookahead unit, with combinational Sum/Error and a registered copy for pipeline capture.
module cla_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        sub,
    output logic [15:0] Sum,
    output logic        Error,
    output logic [15:0] Sum_q,
    output logic        Error_q
);

    logic [15:0] bx;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;       // carry into each bit position
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  blk_c;   // c0, c4, c8, c12, c16

    // Subtraction as A + ~B + 1: invert B and inject the +1 through c0.
    assign bx = B ^ {16{sub}};
    assign g  = A & bx;
    assign p  = A ^ bx;

    for (genvar s = 0; s < 4; s++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic       ci;

        assign gs = g[4*s +: 4];
        assign ps = p[4*s +: 4];
        assign ci = blk_c[s];

        // Every in-slice carry is a flat sum of products from the slice carry-in.
        assign c[4*s +: 4] = {
            gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0]) | (ps[2] & ps[1] & ps[0] & ci),
            gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & ci),
            gs[0] | (ps[0] & ci),
            ci
        };

        assign grp_g[s] = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                        | (ps[3] & ps[2] & ps[1] & gs[0]);
        assign grp_p[s] = &ps;
    end

    // Second-level lookahead across the four slices.
    assign blk_c[0] = sub;
    assign blk_c[1] = grp_g[0] | (grp_p[0] & blk_c[0]);
    assign blk_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & blk_c[0]);
    assign blk_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & blk_c[0]);
    assign blk_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & blk_c[0]);

    assign Sum   = p ^ c;
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign Error = blk_c[4] ^ c[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum_q   <= 16'h0000;
            Error_q <= 1'b0;
        end else begin
            Sum_q   <= Sum;
            Error_q <= Error;
        end
    end

endmodule

// File: tb/tb_cla_16bit.sv
// Scoreboard bench for cla_16bit: checks combinational Sum/Error immediately and the
// registered copy one clock later against a sign-rule reference model.
module tb_cla_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic [15:0] Sum;
    logic        Error;
    logic [15:0] Sum_q;
    logic        Error_q;

    int unsigned n_vec;
    int unsigned n_cmp;
    int unsigned n_err;
    logic [16:0] sb_q[$];   // {error, sum} awaiting registered capture

    cla_16bit u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .sub     (sub),
        .Sum     (Sum),
        .Error   (Error),
        .Sum_q   (Sum_q),
        .Error_q (Error_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        logic [15:0] r;
        logic        ovf;
        r = s ? (a - b) : (a + b);
        if (!s) ovf = (a[15] == b[15]) && (r[15] != a[15]);
        else    ovf = (a[15] != b[15]) && (r[15] != a[15]);
        return {ovf, r};
    endfunction

    // Called just after a rising edge; checks comb now and registered after the next edge.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input string tag);
        logic [16:0] exp;
        A   = a;
        B   = b;
        sub = s;
        n_vec++;
        exp = model(a, b, s);
        #1;
        check({tag, ".sum"}, 32'(Sum), 32'(exp[15:0]));
        check({tag, ".err"}, 32'(Error), 32'(exp[16]));
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sbq"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            check({tag, ".sum_q"}, 32'(Sum_q), 32'(exp[15:0]));
            check({tag, ".err_q"}, 32'(Error_q), 32'(exp[16]));
        end
    endtask

    initial begin
        n_vec = 0;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        sub   = 1'b0;
        #2;
        check("rst.sum_q", 32'(Sum_q), 32'h0);
        check("rst.err_q", 32'(Error_q), 32'h0);
        A = 16'h7FFF;
        B = 16'h0001;
        @(posedge clk);
        #1;
        check("rst_hold.sum_q", 32'(Sum_q), 32'h0);
        check("rst_hold.err_q", 32'(Error_q), 32'h0);
        check("rst_comb.sum", 32'(Sum), 32'h8000);
        check("rst_comb.err", 32'(Error), 32'h1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply(16'h0003, 16'h0004, 1'b0, "add_small");
        apply(16'h7FFF, 16'h0001, 1'b0, "add_povf");
        apply(16'h8000, 16'hFFFF, 1'b0, "add_novf");
        apply(16'h0001, 16'h0005, 1'b1, "sub_neg");
        apply(16'h8000, 16'h0001, 1'b1, "sub_novf");
        apply(16'h7FFF, 16'hFFFF, 1'b1, "sub_povf");
        apply(16'hFFFF, 16'h0001, 1'b0, "add_chain");
        apply(16'h0000, 16'h8000, 1'b1, "sub_min");
        apply(16'h0000, 16'h0000, 1'b1, "sub_zero");
        apply(16'h5555, 16'hAAAA, 1'b0, "add_alt");

        // Load 0x1234 with overflow set, then reset mid-cycle.
        apply(16'h8000, 16'h9234, 1'b0, "load_1234");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.sum_q", 32'(Sum_q), 32'h0);
        check("mid_rst.err_q", 32'(Error_q), 32'h0);
        check("mid_rst.sum", 32'(Sum), 32'h1234);
        check("mid_rst.err", 32'(Error), 32'h1);
        @(posedge clk);
        #1;
        check("in_rst.sum_q", 32'(Sum_q), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release.sum_q", 32'(Sum_q), 32'h1234);
        check("release.err_q", 32'(Error_q), 32'h1);

        for (int i = 0; i < 1100; i++) begin
            apply(16'($urandom), 16'($urandom), (i % 2) == 1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
